// File: rtl/mult_seq_responder.sv
// Responder end of the multiplier req/ack/result_rdy protocol.
// Latches two signed 16-bit operands, optionally checks their even parity, and
// produces the signed 32-bit product with an iterative shift-add datapath that
// consumes BITS_PER_CYCLE multiplier bits per step.
// Optional feature macro: MULT_PARITY_CHECK_EN (operand parity check / ERR path).
module mult_seq_responder #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] arg_a,
    input  logic        arg_a_parity,
    input  logic [15:0] arg_b,
    input  logic        arg_b_parity,
    input  logic        req,
    output logic        ack,
    output logic [31:0] result,
    output logic        result_parity,
    output logic        arg_parity_error,
    output logic        result_rdy
);

    localparam int unsigned N = 16 / BITS_PER_CYCLE;

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 &&
            BITS_PER_CYCLE != 8 && BITS_PER_CYCLE != 16) begin : g_bad_param
            $fatal(1, "mult_seq_responder: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StCalc, StErr, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        ack_q, ack_d;
    logic        rdy_q, rdy_d;
    logic [31:0] result_q, result_d;
    logic        res_par_q, res_par_d;

    // Magnitudes of the signed operands; 0x8000 maps to 32768 as an unsigned value.
    logic [15:0] a_mag, b_mag;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [31:0] partial, acc_step, prod;

    assign a_mag    = arg_a[15] ? 16'(-arg_a) : arg_a;
    assign b_mag    = arg_b[15] ? 16'(-arg_b) : arg_b;
    assign digit    = mplier_q[BITS_PER_CYCLE-1:0];
    assign partial  = mcand_q * 32'(digit);
    assign acc_step = acc_q + partial;
    assign prod     = neg_q ? -acc_step : acc_step;

`ifdef MULT_PARITY_CHECK_EN
    logic perr_q, perr_d;
    logic par_ok;
    assign par_ok = ((^arg_a) == arg_a_parity) && ((^arg_b) == arg_b_parity);
`else
    logic unused_parity;
    assign unused_parity = arg_a_parity ^ arg_b_parity;
`endif

    // Next-state and registered-output computation for the whole responder.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        ack_d     = 1'b0;
        rdy_d     = 1'b0;
        result_d  = result_q;
        res_par_d = res_par_q;
`ifdef MULT_PARITY_CHECK_EN
        perr_d    = perr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    ack_d    = 1'b1;
                    mcand_d  = {16'b0, a_mag};
                    mplier_d = b_mag;
                    acc_d    = 32'b0;
                    cnt_d    = 5'd0;
                    neg_d    = arg_a[15] ^ arg_b[15];
`ifdef MULT_PARITY_CHECK_EN
                    state_d  = par_ok ? StCalc : StErr;
`else
                    state_d  = StCalc;
`endif
                end
            end
            StCalc: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(N - 1)) begin
                    result_d  = prod;
                    res_par_d = ^prod;
                    rdy_d     = 1'b1;
                    state_d   = StDone;
`ifdef MULT_PARITY_CHECK_EN
                    perr_d    = 1'b0;
`endif
                end
            end
`ifdef MULT_PARITY_CHECK_EN
            StErr: begin
                result_d  = 32'b0;
                res_par_d = 1'b0;
                perr_d    = 1'b1;
                rdy_d     = 1'b1;
                state_d   = StDone;
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            mcand_q   <= 32'b0;
            mplier_q  <= 16'b0;
            acc_q     <= 32'b0;
            neg_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdy_q     <= 1'b0;
            result_q  <= 32'b0;
            res_par_q <= 1'b0;
`ifdef MULT_PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            ack_q     <= ack_d;
            rdy_q     <= rdy_d;
            result_q  <= result_d;
            res_par_q <= res_par_d;
`ifdef MULT_PARITY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign ack           = ack_q;
    assign result_rdy    = rdy_q;
    assign result        = result_q;
    assign result_parity = res_par_q;
`ifdef MULT_PARITY_CHECK_EN
    assign arg_parity_error = perr_q;
`else
    assign arg_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_responder.sv
// Self-checking bench for mult_seq_responder: transaction-level model driven by
// cycle timestamps, a per-cycle compare process, and directed literal cases.
module tb_mult_seq_responder;

    localparam int unsigned BPC = 1;
    localparam int N = 16 / BPC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] arg_a = '0, arg_b = '0;
    logic        arg_a_parity = 1'b0, arg_b_parity = 1'b0;
    logic        req = 1'b0;
    logic        ack, result_parity, arg_parity_error, result_rdy;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    mult_seq_responder #(.BITS_PER_CYCLE(BPC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .req              (req),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .arg_parity_error (arg_parity_error),
        .result_rdy       (result_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request at cycle c yields a result at c+L and
    // the next request may be accepted from cycle c+L+2 onward.
    int          cyc = 0;
    int          next_ok = 0;
    int          rdy_at = -1;
    logic [31:0] pend_res = '0;
    logic        pend_err = 1'b0;
    logic        exp_ack = 1'b0, exp_rdy = 1'b0, exp_par = 1'b0, exp_perr = 1'b0;
    logic [31:0] exp_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_ok = 0;
            rdy_at = -1;
            exp_ack = 0; exp_rdy = 0; exp_res = 0; exp_par = 0; exp_perr = 0;
        end else begin
            int lat;
            bit bad;
            cyc++;
            exp_ack = 0;
            exp_rdy = 0;
            if (cyc == rdy_at) begin
                exp_rdy  = 1;
                exp_res  = pend_res;
                exp_par  = ^pend_res;
                exp_perr = pend_err;
            end
            if (cyc >= next_ok && req) begin
                exp_ack = 1;
                bad = 0;
`ifdef MULT_PARITY_CHECK_EN
                bad = ((^arg_a) != arg_a_parity) || ((^arg_b) != arg_b_parity);
`endif
                pend_err = bad;
                pend_res = bad ? 32'd0 : 32'($signed(arg_a) * $signed(arg_b));
                lat = bad ? 1 : N;
                rdy_at = cyc + lat;
                next_ok = cyc + lat + 2;
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("ack", {31'b0, ack}, {31'b0, exp_ack});
        check("result_rdy", {31'b0, result_rdy}, {31'b0, exp_rdy});
        check("result", result, exp_res);
        check("result_parity", {31'b0, result_parity}, {31'b0, exp_par});
        check("arg_parity_error", {31'b0, arg_parity_error}, {31'b0, exp_perr});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One transaction from idle; returns the captured result fields and latency.
    task automatic do_txn(input logic [15:0] a, input logic ap, input logic [15:0] b,
                          input logic bp, output logic [31:0] res, output logic par,
                          output logic perr, output int lat);
        req = 0;
        tick(); tick(); tick();
        arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1;
        tick();
        check("txn_ack", {31'b0, ack}, 32'd1);
        req = 0;
        arg_a = 16'h5A5A; arg_b = 16'hA5A5;
        lat = 0;
        res = 'x; par = 'x; perr = 'x;
        while (lat < 40) begin
            tick();
            lat++;
            if (result_rdy) begin
                res = result; par = result_parity; perr = arg_parity_error;
                break;
            end
        end
        if (lat >= 40) begin
            failures++;
            $display("FAIL txn_timeout actual=no_result_rdy required=result_rdy");
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic p, e;
        int lat, last, gap;

        tick(); tick();
        check("reset_result", result, 32'd0);
        check("reset_flags", {28'b0, ack, result_rdy, result_parity, arg_parity_error}, 32'd0);
        rst_n = 1;
        tick();

        do_txn(16'd3, 1'b0, 16'd5, 1'b0, r, p, e, lat);
        check("basic_result", r, 32'd15);
        check("basic_parity", {31'b0, p}, 32'd0);
        check("basic_perr", {31'b0, e}, 32'd0);
        check("basic_latency", 32'(lat), 32'(N));

        do_txn(16'h8000, 1'b1, 16'h8000, 1'b1, r, p, e, lat);
        check("minneg_result", r, 32'h4000_0000);
        check("minneg_parity", {31'b0, p}, 32'd1);

        do_txn(16'hFFFF, 1'b0, 16'd2, 1'b1, r, p, e, lat);
        check("mixed_result", r, 32'hFFFF_FFFE);
        check("mixed_parity", {31'b0, p}, 32'd1);

        do_txn(16'd7, 1'b0, 16'd1, 1'b1, r, p, e, lat);
`ifdef MULT_PARITY_CHECK_EN
        check("perr_result", r, 32'd0);
        check("perr_flag", {31'b0, e}, 32'd1);
        check("perr_latency", 32'(lat), 32'd1);
`else
        check("perr_result", r, 32'd7);
        check("perr_flag", {31'b0, e}, 32'd0);
        check("perr_latency", 32'(lat), 32'(N));
`endif

        // Reset in the middle of CALC drops the transaction.
        tick(); tick(); tick();
        arg_a = 16'd9; arg_a_parity = 1'b0; arg_b = 16'd9; arg_b_parity = 1'b0; req = 1;
        tick();
        req = 0;
        repeat (8) tick();
        rst_n = 0;
        #1;
        check("midrst_outputs",
              {result[27:0], ack, result_rdy, result_parity, arg_parity_error}, 32'd0);
        check("midrst_result", result, 32'd0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_rdy) check("midrst_no_rdy", 32'd1, 32'd0);
        end
        do_txn(16'd2, 1'b1, 16'd3, 1'b0, r, p, e, lat);
        check("post_rst_result", r, 32'd6);
        check("post_rst_latency", 32'(lat), 32'(N));

        // Held request: accepts every N+2 cycles.
        tick(); tick();
        arg_a = 16'd100; arg_a_parity = ^arg_a;
        arg_b = 16'hFF9C; arg_b_parity = ^arg_b;
        req = 1;
        last = -1;
        for (int t = 0; t < 4 * (N + 2) + 2; t++) begin
            tick();
            if (ack) begin
                if (last >= 0) begin
                    gap = t - last;
                    check("held_period", 32'(gap), 32'(N + 2));
                end
                last = t;
            end
            if (result_rdy) check("held_result", result, 32'hFFFF_D8F0);
        end
        req = 0;
        repeat (N + 4) tick();

        // Randomized traffic with occasional resets and bad parity.
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end
            req = ($urandom_range(0, 3) != 0);
            arg_a = pick();
            arg_b = pick();
            arg_a_parity = (^arg_a) ^ ($urandom_range(0, 7) == 0);
            arg_b_parity = (^arg_b) ^ ($urandom_range(0, 7) == 0);
        end
        req = 0;
        repeat (N + 4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
